reg_file_wb: RTL
================

// Module: reg_file_wb
// PURPOSE
//   32x32 MIPS register file. Sources ReadData1/ReadData2 for the ALU and the ALU_B operand mux.
//   Sinks two write-back streams on a single write port: ALU results and load data.
//   A 1-entry hold buffer absorbs ALU/load collisions; read-side bypass hides write latency.
//   Sits between MEM/WB and the ID-stage operand path.
// PARAMETERS
//   DATA_W    32  register / data width
//   ADDR_W    5   register index width
//   NUM_REGS  32  register count; entry 0 hardwired to zero
// PORTS
//   Clk          in   1       core clock, rising edge
//   Rst_n        in   1       asynchronous reset, active low
//   ReadReg1     in   ADDR_W  read port 1 index (rs)
//   ReadReg2     in   ADDR_W  read port 2 index (rt)
//   ReadData1    out  DATA_W  read port 1 data, combinational
//   ReadData2    out  DATA_W  read port 2 data, combinational
//   AluWrValid   in   1       ALU write-back request; always accepted
//   AluWrReg     in   ADDR_W  ALU destination register
//   AluWrData    in   DATA_W  ALU result
//   MemWrValid   in   1       load write-back request
//   MemWrReg     in   ADDR_W  load destination register
//   MemWrData    in   DATA_W  load data
//   MemWrReady   out  1       load write accepted when MemWrValid & MemWrReady
//   WbConflicts  out  16      saturating count of ALU/load collisions
// BEHAVIOUR
//   Reset (async, Rst_n=0):
//     - all registers = 0; hold buffer invalid; state EMPTY; WbConflicts = 0; MemWrReady = 1.
//   Reads:
//     - zero-latency; index 0 always returns 0.
//     - Source priority: ALU write this cycle > load commit this cycle > hold buffer > array.
//   Write port: one commit per rising edge. Writes to index 0 are dropped (never buffered).
//   FSM, 2 states:
//     EMPTY (MemWrReady=1)
//       - ALU only: ALU commits.
//       - Load only: load commits.
//       - Both valid, load dest != 0:
//           ALU commits; load captured into hold buffer; -> HELD; WbConflicts += 1.
//     HELD (MemWrReady=0)
//       - No ALU write: buffer commits -> EMPTY.
//       - ALU write, different dest: ALU commits; stay HELD.
//       - ALU write, same dest as buffer: ALU commits; buffer killed (ALU is younger) -> EMPTY.
//       - New load requests are not accepted; the load source must hold them.
//   WbConflicts saturates at 16'hFFFF; it never wraps.
//   Reset mid-HELD: buffered data is discarded; no commit occurs.
//   Unsupported input: ALU and load with the same dest in the same cycle; flagged by an assertion in simulation only.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - read bypass as above; a same-cycle write is visible on ReadData*.
//   REGFILE_BYPASS_EN undefined:
//     - read-before-write; reads return array contents plus the hold buffer only.
//     - A write is visible on the cycle after commit. Hazards are resolved by the pipeline stall logic.
// TESTING
//   1. Reset, then read all 32 indices -> every ReadData = 0; MemWrReady = 1; WbConflicts = 0.
//   2. ALU write r5 = 32'hDEADBEEF with ReadReg2 = 5 in the same cycle
//        -> BYPASS_EN: ReadData2 = DEADBEEF that cycle; without: old value that cycle, DEADBEEF next cycle.
//   3. ALU r3 = 1 and load r4 = 2 in the same cycle
//        -> r3 = 1 at the edge; MemWrReady = 0 for 1 cycle; r4 = 2 one edge later; WbConflicts = 1.
//   4. Collision holds load r7 = 9; next cycle ALU writes r7 = 8
//        -> buffer killed; r7 = 8; MemWrReady = 1 the following cycle.
//   5. Write r0 = FFFFFFFF from both sources -> ReadData1 (ReadReg1 = 0) = 0; no HELD entry.
//   6. Force 70000 collisions -> WbConflicts = 16'hFFFF; assert Rst_n while HELD -> buffer dropped.

Source files
------------

// File: rtl/reg_file_wb.sv
// 32x32 register file with one write port shared by ALU and load write-back, a 1-entry hold buffer for collisions.
// Optional same-cycle read bypass when REGFILE_BYPASS_EN is defined.
module reg_file_wb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              AluWrValid,
  input  logic [ADDR_W-1:0] AluWrReg,
  input  logic [DATA_W-1:0] AluWrData,
  input  logic              MemWrValid,
  input  logic [ADDR_W-1:0] MemWrReg,
  input  logic [DATA_W-1:0] MemWrData,
  output logic              MemWrReady,
  output logic [15:0]       WbConflicts
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [ADDR_W-1:0]   hold_reg_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [CNT_W-1:0]    wb_conflicts_q;

  logic                mem_acc;
  logic                alu_nz;
  logic                mem_nz;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                hold_ld;
  logic                cnt_inc;

  assign mem_acc     = MemWrValid && (state_q == EMPTY);
  assign alu_nz      = (AluWrReg != '0);
  assign mem_nz      = (MemWrReg != '0);
  assign MemWrReady  = (state_q == EMPTY);
  assign WbConflicts = wb_conflicts_q;

  // Write-port arbitration and hold-buffer control
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = AluWrReg;
    wr_data = AluWrData;
    hold_ld = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      EMPTY: begin
        if (AluWrValid) begin
          wr_en = alu_nz;
          if (MemWrValid && mem_nz) begin
            hold_ld = 1'b1;
            cnt_inc = 1'b1;
            state_d = HELD;
          end
        end else if (MemWrValid) begin
          wr_en   = mem_nz;
          wr_addr = MemWrReg;
          wr_data = MemWrData;
        end
      end
      HELD: begin
        if (!AluWrValid) begin
          wr_en   = 1'b1;
          wr_addr = hold_reg_q;
          wr_data = hold_data_q;
          state_d = EMPTY;
        end else begin
          // A younger ALU write to the buffered register supersedes the load
          wr_en = alu_nz;
          if (AluWrReg == hold_reg_q) state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= EMPTY;
      hold_reg_q     <= '0;
      hold_data_q    <= '0;
      wb_conflicts_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) regs_q[wr_addr] <= wr_data;
      if (hold_ld) begin
        hold_reg_q  <= MemWrReg;
        hold_data_q <= MemWrData;
      end
      if (cnt_inc && (wb_conflicts_q != '1)) wb_conflicts_q <= wb_conflicts_q + CNT_W'(1);
    end
  end

  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = regs_q[idx];
    if ((state_q == HELD) && (hold_reg_q == idx)) v = hold_data_q;
`ifdef REGFILE_BYPASS_EN
    if (mem_acc && (MemWrReg == idx)) v = MemWrData;
    if (AluWrValid && (AluWrReg == idx)) v = AluWrData;
`endif
    if (idx == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    ReadData1 = rd_val(ReadReg1);
    ReadData2 = rd_val(ReadReg2);
  end

`ifndef SYNTHESIS
  // Same-destination ALU and accepted load in one cycle is not a legal input
  assert property (@(posedge Clk) disable iff (!Rst_n)
    !(AluWrValid && mem_acc && mem_nz && (AluWrReg == MemWrReg)));
`endif

endmodule
